// File: rtl/judge_sequencer.sv
// judge_sequencer: game-flow controller for the rhythm game score datapath.
// Turns judgement events into a one-cycle increment code plus a running combo,
// tracks misses and best combo, and owns the IDLE/PLAY/PAUSE/DONE flow.
module judge_sequencer #(
  parameter int unsigned MISS_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       song_end,
  input  logic       hit_valid,
  input  logic [1:0] hit_grade,
  output logic [1:0] inp,
  output logic [7:0] combo,
  output logic [7:0] max_combo,
  output logic [7:0] miss_cnt,
  output logic       score_clr,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [7:0] LIMIT = 8'(MISS_LIMIT);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_inp;
  logic [7:0] r_combo;
  logic [7:0] r_max_combo;
  logic [7:0] r_miss_cnt;
  logic       r_score_clr;
  logic       r_game_over;

  logic       w_hit_ok;
  logic       w_miss;
  logic       w_start_run;
  logic [7:0] w_combo_inc;
  logic [7:0] w_miss_inc;

  // Saturating successors; the limit check uses the post-miss count.
  assign w_combo_inc = (r_combo == 8'hFF) ? 8'hFF : (r_combo + 8'd1);
  assign w_miss_inc  = (r_miss_cnt == 8'hFF) ? 8'hFF : (r_miss_cnt + 8'd1);

  // Next-state and per-cycle hit qualification; hits only count in PLAY.
  always_comb begin
    w_next_state = r_state;
    w_hit_ok     = 1'b0;
    w_miss       = 1'b0;
    w_start_run  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_PLAY;
          w_start_run  = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_PLAY: begin
        w_hit_ok = hit_valid && (hit_grade != 2'b00);
        w_miss   = hit_valid && (hit_grade == 2'b00);
        // song_end beats the miss limit, which beats pause
        if (song_end) begin
          w_next_state = S_DONE;
        end else if (w_miss && (w_miss_inc == LIMIT)) begin
          w_next_state = S_DONE;
        end else if (pause) begin
          w_next_state = S_PAUSE;
        end else begin
          w_next_state = S_PLAY;
        end
      end
      S_PAUSE: begin
        if (pause) begin
          w_next_state = S_PLAY;
        end else begin
          w_next_state = S_PAUSE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_next_state = S_PLAY;
          w_start_run  = 1'b1;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register plus status flags derived from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_score_clr <= 1'b1;
      r_game_over <= 1'b0;
      r_inp       <= 2'b00;
    end else begin
      r_state     <= w_next_state;
      r_score_clr <= w_start_run;
      r_game_over <= (w_next_state == S_DONE);
      r_inp       <= w_hit_ok ? hit_grade : 2'b00;
    end
  end

  // Combo / best combo / miss counters: cleared on a new run, frozen outside PLAY.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_combo     <= 8'd0;
      r_max_combo <= 8'd0;
      r_miss_cnt  <= 8'd0;
    end else if (w_start_run) begin
      r_combo     <= 8'd0;
      r_max_combo <= 8'd0;
      r_miss_cnt  <= 8'd0;
    end else if (w_hit_ok) begin
      r_combo <= w_combo_inc;
      if (w_combo_inc > r_max_combo) begin
        r_max_combo <= w_combo_inc;
      end
    end else if (w_miss) begin
      r_combo    <= 8'd0;
      r_miss_cnt <= w_miss_inc;
    end
  end

  assign inp       = r_inp;
  assign combo     = r_combo;
  assign max_combo = r_max_combo;
  assign miss_cnt  = r_miss_cnt;
  assign score_clr = r_score_clr;
  assign state     = r_state;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_judge_sequencer.sv
// Self-checking bench for judge_sequencer: directed scenarios from the test
// plan followed by randomized play, all compared against a behavioural model.
module tb_judge_sequencer;

  localparam int LIM = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       song_end = 1'b0;
  logic       hit_valid = 1'b0;
  logic [1:0] hit_grade = 2'b00;
  logic [1:0] inp;
  logic [7:0] combo;
  logic [7:0] max_combo;
  logic [7:0] miss_cnt;
  logic       score_clr;
  logic [1:0] state;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game rules in plain integers.
  // Phase numbering: 0 idle, 1 playing, 2 paused, 3 done.
  int m_phase = 0;
  int m_inp   = 0;
  int m_combo = 0;
  int m_max   = 0;
  int m_miss  = 0;
  int m_clr   = 0;

  judge_sequencer #(.MISS_LIMIT(LIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .song_end  (song_end),
    .hit_valid (hit_valid),
    .hit_grade (hit_grade),
    .inp       (inp),
    .combo     (combo),
    .max_combo (max_combo),
    .miss_cnt  (miss_cnt),
    .score_clr (score_clr),
    .state     (state),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic new_run_model();
    m_phase = 1;
    m_clr   = 1;
    m_combo = 0;
    m_max   = 0;
    m_miss  = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit ended_by_miss;
    ended_by_miss = 0;
    if (reset) begin
      m_phase = 0; m_inp = 0; m_combo = 0; m_max = 0; m_miss = 0; m_clr = 1;
      return;
    end
    m_clr = 0;
    m_inp = 0;
    if (m_phase == 0) begin
      if (start) new_run_model();
    end else if (m_phase == 1) begin
      if (hit_valid) begin
        if (hit_grade != 0) begin
          m_inp   = hit_grade;
          m_combo = (m_combo + 1 > 255) ? 255 : m_combo + 1;
          if (m_combo > m_max) m_max = m_combo;
        end else begin
          m_combo = 0;
          m_miss  = (m_miss + 1 > 255) ? 255 : m_miss + 1;
          ended_by_miss = (m_miss == LIM);
        end
      end
      if (song_end)           m_phase = 3;
      else if (ended_by_miss) m_phase = 3;
      else if (pause)         m_phase = 2;
    end else if (m_phase == 2) begin
      if (pause) m_phase = 1;
    end else begin
      if (start) new_run_model();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("state",     state,     m_phase);
    check("inp",       inp,       m_inp);
    check("combo",     combo,     m_combo);
    check("max_combo", max_combo, m_max);
    check("miss_cnt",  miss_cnt,  m_miss);
    check("score_clr", score_clr, m_clr);
    check("game_over", game_over, (m_phase == 3) ? 1 : 0);
  endtask

  task automatic drive(input logic rs, input logic st, input logic ps, input logic se,
                       input logic hv, input logic [1:0] g);
    reset = rs; start = st; pause = ps; song_end = se; hit_valid = hv; hit_grade = g;
    step();
  endtask

  task automatic new_run();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    // Reset and first start
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check("rst_clr", score_clr, 1);
    check("rst_state", state, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);   // IDLE ignores hits
    check("idle_clr", score_clr, 0);
    check("idle_inp", inp, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check("start_state", state, 1);
    check("start_clr", score_clr, 1);
    check("start_combo", combo, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);   // start held in PLAY is ignored
    check("clr_once", score_clr, 0);

    // Three perfects back to back
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
      check("perf_inp", inp, 3);
      check("perf_combo", combo, i);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check("perf_idle_inp", inp, 0);
    check("perf_max", max_combo, 3);

    // 01, 10, miss
    new_run();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    check("gl_inp", inp, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    check("gr_inp", inp, 2);
    check("gr_combo", combo, 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    check("miss_inp", inp, 0);
    check("miss_combo", combo, 0);
    check("miss_max", max_combo, 2);
    check("miss_cnt1", miss_cnt, 1);

    // Miss limit ends the run
    new_run();
    for (int i = 0; i < LIM; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    check("lim_state", state, 3);
    check("lim_go", game_over, 1);
    check("lim_miss", miss_cnt, LIM);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    check("done_inp", inp, 0);
    check("done_combo", combo, 0);

    // Pause / resume
    new_run();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check("pause_state", state, 2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
      check("paused_inp", inp, 0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check("resume_state", state, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    check("resume_inp", inp, 3);
    check("resume_combo", combo, 1);

    // Hit coinciding with song_end is still scored; restart from DONE clears
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    check("se_state", state, 3);
    check("se_inp", inp, 2);
    check("se_combo", combo, 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check("restart_clr", score_clr, 1);
    check("restart_max", max_combo, 0);

    // Combo saturation then reset mid-run
    new_run();
    for (int i = 0; i < 258; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    check("sat_combo", combo, 255);
    check("sat_max", max_combo, 255);
    check("sat_inp", inp, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
    check("midrst_state", state, 0);
    check("midrst_combo", combo, 0);
    check("midrst_max", max_combo, 0);
    check("midrst_clr", score_clr, 1);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 149) == 0),
            ($urandom_range(0, 1) == 1),
            2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/judge_sequencer.md
# judge_sequencer

Game-flow controller that sequences the score datapath of the rhythm game. It turns per-note judgement events into a one-cycle score-increment code and a running combo, and owns the play / pause / done state machine. It also issues the clear pulse for the score counter and tracks misses and the best combo. It sits between the note-judgement logic and the score counter: its `inp`, `combo` and `score_clr` drive the counter's `Inp`, `combo` and `reset`.

## Interface
- `MISS_LIMIT`, default 8: number of misses in one run that ends the run (1..255).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level, sampled each cycle; begins a new run from IDLE or DONE.
- `pause`  in  1  single-cycle pulse; toggles between PLAY and PAUSE.
- `song_end`  in  1  single-cycle pulse; the chart is finished.
- `hit_valid`  in  1  single-cycle pulse; a judgement is present on `hit_grade`.
- `hit_grade`  in  2  00 miss, 01 good-left, 10 good-right, 11 perfect.
- `inp`  out  2  score increment code to the score counter; 00 except for one cycle per accepted hit.
- `combo`  out  8  current combo, saturating at 255.
- `max_combo`  out  8  highest `combo` reached in the current run.
- `miss_cnt`  out  8  misses in the current run.
- `score_clr`  out  1  one-cycle clear pulse to the score counter.
- `state`  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 DONE.
- `game_over`  out  1  high while in DONE.

## Operation
- All outputs are registered.
- **Reset values:**
  - `state` = IDLE.
  - `inp`, `combo`, `max_combo`, `miss_cnt` = 0.
  - `game_over` = 0.
  - `score_clr` = 1 for the reset cycle only, then 0.
- **IDLE:**
  - Ignores `hit_valid`, `pause` and `song_end`.
  - `start`=1 → PLAY. On the same edge: `score_clr`=1 for one cycle; `combo`, `max_combo` and `miss_cnt` cleared.
- **PLAY, `hit_valid` with grade ≠ 00:**
  - `inp` ← `hit_grade`.
  - `combo` ← `combo`+1, saturating at 255.
  - `max_combo` ← max(`max_combo`, new `combo`).
- **PLAY, `hit_valid` with grade = 00:**
  - `inp` ← 00 and `combo` ← 0.
  - `miss_cnt` ← `miss_cnt`+1, saturating at 255.
- **PLAY, cycles with no `hit_valid`:** `inp` ← 00.
- **PLAY, transitions**, evaluated after the hit is processed. Priority: `song_end` > miss limit > `pause`.
  - `song_end` → DONE.
  - Incremented `miss_cnt` == `MISS_LIMIT` → DONE.
  - `pause` → PAUSE.
- **PAUSE:**
  - `inp` = 00; `hit_valid` and `song_end` are ignored.
  - Counters are held.
  - `pause` → PLAY.
- **DONE:**
  - `game_over` = 1; `inp` = 00.
  - `combo`, `max_combo` and `miss_cnt` are frozen for display.
  - `start` → PLAY with the same clear as from IDLE.
- `start` in PLAY or PAUSE is ignored; no restart mid-run.
- `hit_grade` is don't-care when `hit_valid` = 0.

## Timing
- **Hit path:**
  - `hit_valid` sampled at edge N; `inp`/`combo` valid after edge N.
  - The score counter adds at edge N+1 using that `combo`, which is the post-hit value.
- **`inp` width:** exactly one cycle per accepted hit. Back-to-back hits on consecutive cycles give consecutive non-zero `inp` cycles with `combo` incrementing each cycle.
- **Clear:** `score_clr` is asserted in the first PLAY cycle. `inp` is 00 in that cycle, so no increment is lost to the clear.
- **Simultaneous hit and transition:** a hit in the same cycle as `song_end`, `pause` or the limit-reaching miss is still scored. Its `inp` cycle coincides with the first DONE/PAUSE cycle.
- **Saturation boundaries:**
  - `combo` at 255 plus a hit stays 255; `max_combo` stays 255.
  - `miss_cnt` never wraps.
- **Reset mid-run:** synchronous `reset` in any state wins over all other inputs at that edge. Results: IDLE, counters 0, `score_clr` pulse.

## Test plan
- Reset, `start`=1 one cycle → `state`=01, `score_clr`=1 for exactly one cycle, `combo`=0.
- In PLAY, 3 hits of grade 11 on consecutive cycles → `inp`=11,11,11 then 00; `combo`=1,2,3; `max_combo`=3.
- Hits 01, 10, then miss → `inp`=01,10,00; `combo`=1,2,0; `max_combo`=2; `miss_cnt`=1.
- `MISS_LIMIT`=8, 8 misses → DONE after the 8th (`game_over`=1, `miss_cnt`=8); a further hit leaves `inp`=00 and `combo` unchanged.
- `pause` pulse, hits while paused, `pause` again, one hit 11 → paused hits ignored, `inp`=00; after resume `inp`=11 and `combo`+1.
- 256 consecutive hits grade 01 → `combo` saturates at 255, `max_combo`=255. Then `reset` during PLAY → IDLE, all counters 0.
